// File: rtl/stack_ctrl_if.sv
// Pipeline/memory-side bus of the stack sequencer: op request, memory strobes
// and selects, popped-data response and sticky stack flags.
interface stack_ctrl_if;
    logic       op_valid;
    logic [1:0] op_code;
    logic       op_ready;
    logic [7:0] sp_out;
    logic       sel_sp;
    logic       sel_rn;
    logic       mem_rd;
    logic       mem_wr;
    logic [7:0] mem_rdata;
    logic       rsp_valid;
    logic       rsp_ret;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       stk_ovf;
    logic       stk_unf;

    modport master (
        output op_valid, op_code, mem_rdata,
        input  op_ready, sp_out, sel_sp, sel_rn, mem_rd, mem_wr,
               rsp_valid, rsp_ret, rsp_data, rsp_err, stk_ovf, stk_unf
    );

    modport slave (
        input  op_valid, op_code, mem_rdata,
        output op_ready, sp_out, sel_sp, sel_rn, mem_rd, mem_wr,
               rsp_valid, rsp_ret, rsp_data, rsp_err, stk_ovf, stk_unf
    );
endinterface

// File: rtl/stack_ctrl.sv
// Memory-stage stack sequencer (empty-descending stack) running PUSH/POP/CALL/RET.
// Define STACK_BOUNDS_CHECK_EN to enable full/empty detection, sticky flags and rsp_err.
module stack_ctrl #(
    parameter logic [7:0] SP_RESET = 8'hFF,
    parameter logic [7:0] SP_LIMIT = 8'h80
) (
    input logic         clk,
    input logic         rst_n,
    stack_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WRITE = 2'b01,
        ST_READ  = 2'b10,
        ST_RESP  = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,
        OP_POP  = 2'b01,
        OP_CALL = 2'b10,
        OP_RET  = 2'b11
    } op_e;

    state_e     state_q, state_d;
    op_e        op_q, op_d;
    op_e        op_in;
    logic [7:0] sp_q, sp_d;
    logic       err_q, err_d;
    logic       ready_q, ready_d;
    logic       sel_sp_q, sel_sp_d;
    logic       sel_rn_q, sel_rn_d;
    logic       rd_q, rd_d;
    logic       wr_q, wr_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       rsp_ret_q, rsp_ret_d;
    logic       rsp_err_q, rsp_err_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       ovf_q, ovf_d;
    logic       unf_q, unf_d;
    logic       full;
    logic       empty;

`ifdef STACK_BOUNDS_CHECK_EN
    assign full  = (sp_q == SP_LIMIT - 8'd1);
    assign empty = (sp_q == SP_RESET);
`else
    assign full  = 1'b0;
    assign empty = 1'b0;
`endif

    assign op_in = op_e'(bus.op_code);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        sp_d       = sp_q;
        err_d      = err_q;
        rsp_data_d = rsp_data_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.op_valid) begin
                    op_d  = op_in;
                    err_d = 1'b0;
                    if (op_in == OP_PUSH || op_in == OP_CALL) begin
                        if (full) begin
                            ovf_d = 1'b1;
                        end else begin
                            state_d = ST_WRITE;
                        end
                    end else begin
                        state_d = ST_READ;
                        if (empty) begin
                            unf_d = 1'b1;
                            err_d = 1'b1;
                        end else begin
                            sp_d = sp_q + 8'd1;
                        end
                    end
                end
            end
            ST_WRITE: begin
                sp_d    = sp_q - 8'd1;
                state_d = ST_IDLE;
            end
            ST_READ: begin
                rsp_data_d = err_q ? '0 : bus.mem_rdata;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so every output is a flop.
        ready_d     = (state_d == ST_IDLE);
        sel_sp_d    = (state_d == ST_WRITE) || (state_d == ST_READ);
        sel_rn_d    = (state_d == ST_WRITE) && (op_d == OP_PUSH);
        wr_d        = (state_d == ST_WRITE);
        rd_d        = (state_d == ST_READ) && !err_d;
        rsp_valid_d = (state_d == ST_RESP);
        rsp_ret_d   = (state_d == ST_RESP) && (op_d == OP_RET);
        rsp_err_d   = (state_d == ST_RESP) && err_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_PUSH;
            sp_q        <= SP_RESET;
            err_q       <= 1'b0;
            ready_q     <= 1'b1;
            sel_sp_q    <= 1'b0;
            sel_rn_q    <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_ret_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            sp_q        <= sp_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
            sel_sp_q    <= sel_sp_d;
            sel_rn_q    <= sel_rn_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_ret_q   <= rsp_ret_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    assign bus.op_ready  = ready_q;
    assign bus.sp_out    = sp_q;
    assign bus.sel_sp    = sel_sp_q;
    assign bus.sel_rn    = sel_rn_q;
    assign bus.mem_rd    = rd_q;
    assign bus.mem_wr    = wr_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_ret   = rsp_ret_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.stk_ovf   = ovf_q;
    assign bus.stk_unf   = unf_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: byte memory environment, timeline-based stack model,
// per-cycle output compare, directed scenarios and a randomized phase.
`timescale 1ns/1ps
module tb_stack_ctrl;

    localparam logic [7:0] SP_RESET = 8'hFF;
    localparam logic [7:0] SP_LIMIT = 8'hF8;
`ifdef STACK_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stack_ctrl_if bus ();

    stack_ctrl #(.SP_RESET(SP_RESET), .SP_LIMIT(SP_LIMIT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Environment: data memory with combinational read; Rn and NPC sources.
    logic [7:0] rn, npc;
    logic [7:0] env_mem [256];
    assign bus.mem_rdata = env_mem[bus.sp_out];
    always @(posedge clk) begin
        if (rst_n && bus.mem_wr) env_mem[bus.sp_out] <= bus.sel_rn ? rn : npc;
    end

    // Model: per-cycle expectations queued at accept; empty queue means idle.
    typedef struct packed {
        logic       sel_sp;
        logic       sel_rn;
        logic       rd;
        logic       wr;
        logic       rv;
        logic       ret;
        logic       err;
        logic [7:0] sp;
        logic [7:0] data;
    } cyc_t;

    cyc_t       tl[$];
    cyc_t       m_pop;
    logic [7:0] m_sp;
    logic [7:0] m_last;
    bit         m_ovf, m_unf;
    logic [7:0] m_mem [256];

    task automatic model_accept(input logic [1:0] op);
        cyc_t c1, c2;
        c1 = '0;
        c2 = '0;
        if (op == 2'b00 || op == 2'b10) begin
            if (BOUNDS && m_sp == SP_LIMIT - 8'd1) begin
                m_ovf = 1'b1;
            end else begin
                c1.sp = m_sp; c1.sel_sp = 1'b1; c1.wr = 1'b1; c1.sel_rn = (op == 2'b00);
                tl.push_back(c1);
                m_sp = m_sp - 8'd1;
            end
        end else begin
            if (BOUNDS && m_sp == SP_RESET) begin
                m_unf = 1'b1;
                c2.err = 1'b1;
                c2.data = 8'h00;
            end else begin
                m_sp = m_sp + 8'd1;
                c1.rd = 1'b1;
                c2.data = m_mem[m_sp];
            end
            c1.sp = m_sp; c1.sel_sp = 1'b1;
            c2.sp = m_sp; c2.rv = 1'b1; c2.ret = (op == 2'b11);
            tl.push_back(c1);
            tl.push_back(c2);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tl.delete();
            m_sp = SP_RESET;
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_last = 8'h00;
        end else if (tl.size() > 0) begin
            m_pop = tl.pop_front();
            if (m_pop.wr) m_mem[m_pop.sp] = m_pop.sel_rn ? rn : npc;
            if (m_pop.rv) m_last = m_pop.data;
        end else if (bus.op_valid) begin
            model_accept(bus.op_code);
        end
    end

    // Every-cycle compare of all outputs against the model.
    cyc_t        e_cur;
    logic [31:0] e_vec, a_vec;
    always @(negedge clk) begin
        if (rst_n) begin
            if (tl.size() > 0) e_cur = tl[0];
            else begin
                e_cur = '0;
                e_cur.sp = m_sp;
            end
            e_vec = {6'd0, (tl.size() == 0), e_cur.sp, e_cur.sel_sp, e_cur.sel_rn, e_cur.rd,
                     e_cur.wr, e_cur.rv, e_cur.ret, e_cur.err, m_ovf, m_unf,
                     (e_cur.rv ? e_cur.data : m_last)};
            a_vec = {6'd0, bus.op_ready, bus.sp_out, bus.sel_sp, bus.sel_rn, bus.mem_rd,
                     bus.mem_wr, bus.rsp_valid, bus.rsp_ret, bus.rsp_err, bus.stk_ovf,
                     bus.stk_unf, bus.rsp_data};
            check("cycle", a_vec, e_vec);
        end
    end

    // Observations collected by do_op.
    logic [7:0] s_sp, rsp_d;
    logic       s_rn, s_wr, s_rd, rsp_seen, rsp_r, rsp_e, rd_seen, wr_seen;
    int         lat;

    task automatic do_op(input logic [1:0] code, input logic [7:0] val);
        @(negedge clk); #1;
        if (code == 2'b00) rn = val;
        if (code == 2'b10) npc = val;
        bus.op_valid = 1'b1;
        bus.op_code  = code;
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        bus.op_code  = 2'($urandom);
        s_sp = bus.sp_out; s_rn = bus.sel_rn; s_wr = bus.mem_wr; s_rd = bus.mem_rd;
        rd_seen = bus.mem_rd; wr_seen = bus.mem_wr;
        rsp_seen = 1'b0; rsp_d = 8'h00; rsp_r = 1'b0; rsp_e = 1'b0;
        lat = 1;
        while (!bus.op_ready && lat < 10) begin
            if (bus.rsp_valid) begin
                rsp_seen = 1'b1; rsp_d = bus.rsp_data; rsp_r = bus.rsp_ret; rsp_e = bus.rsp_err;
            end
            @(posedge clk); #1;
            lat++;
            rd_seen = rd_seen | bus.mem_rd;
            wr_seen = wr_seen | bus.mem_wr;
        end
        if (!bus.op_ready) check("op_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.op_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1;
    endtask

    int wr_cnt;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.op_valid = 1'b0;
        bus.op_code  = 2'b00;
        rn = 8'h00;
        npc = 8'h00;
        for (int unsigned i = 0; i < 256; i++) begin
            env_mem[i] = 8'(i * 3 + 7);
            m_mem[i]   = 8'(i * 3 + 7);
        end
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        check("rst_ready", {31'd0, bus.op_ready}, 32'd1);
        check("rst_sp", {24'd0, bus.sp_out}, 32'h0000_00FF);
        check("rst_strobes", {26'd0, bus.mem_wr, bus.mem_rd, bus.sel_sp, bus.sel_rn, bus.rsp_valid, bus.rsp_err}, 32'd0);
        check("rst_flags", {30'd0, bus.stk_ovf, bus.stk_unf}, 32'd0);

        // 1: reset while in WRITE aborts the write at once
        @(negedge clk); #1;
        rn = 8'hAA;
        bus.op_valid = 1'b1;
        bus.op_code  = 2'b00;
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        check("t1_in_write", {31'd0, bus.mem_wr}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t1_wr_drop", {31'd0, bus.mem_wr}, 32'd0);
        check("t1_sp", {24'd0, bus.sp_out}, 32'h0000_00FF);
        check("t1_ready", {31'd0, bus.op_ready}, 32'd1);
        check("t1_flags", {30'd0, bus.stk_ovf, bus.stk_unf}, 32'd0);
        @(posedge clk); #1;
        check("t1_no_write", {24'd0, env_mem[8'hFF]}, 32'h0000_0004);
        @(negedge clk); #1;
        rst_n = 1'b1;

        // 2: PUSH Rn then POP
        do_op(2'b00, 8'h5A);
        check("t2_push_addr", {24'd0, s_sp}, 32'h0000_00FF);
        check("t2_push_sel", {30'd0, s_rn, s_wr}, 32'd3);
        check("t2_push_lat", lat, 32'd2);
        check("t2_push_sp", {24'd0, bus.sp_out}, 32'h0000_00FE);
        do_op(2'b01, 8'h00);
        check("t2_pop_rd", {31'd0, s_rd}, 32'd1);
        check("t2_pop_rsp", {22'd0, rsp_seen, rsp_r, rsp_e, rsp_d}, {22'd0, 3'b100, 8'h5A});
        check("t2_pop_lat", lat, 32'd3);
        check("t2_pop_sp", {24'd0, bus.sp_out}, 32'h0000_00FF);

        // 3: CALL NPC then RET
        do_op(2'b10, 8'h3C);
        check("t3_call_sel", {22'd0, s_rn, s_wr, s_sp}, {22'd0, 2'b01, 8'hFF});
        check("t3_call_mem", {24'd0, env_mem[8'hFF]}, 32'h0000_003C);
        do_op(2'b11, 8'h00);
        check("t3_ret_rsp", {22'd0, rsp_seen, rsp_r, rsp_e, rsp_d}, {22'd0, 3'b110, 8'h3C});

        // 4: fill the stack, then one more PUSH
        do_reset();
        for (int k = 0; k < 8; k++) do_op(2'b00, 8'(8'h10 + k));
`ifdef STACK_BOUNDS_CHECK_EN
        check("t4_sp_full", {24'd0, bus.sp_out}, 32'h0000_00F7);
        do_op(2'b00, 8'hEE);
        check("t4_ovf_nowr", {31'd0, wr_seen}, 32'd0);
        check("t4_ovf_lat", lat, 32'd1);
        check("t4_ovf_sp", {24'd0, bus.sp_out}, 32'h0000_00F7);
        check("t4_ovf_flag", {31'd0, bus.stk_ovf}, 32'd1);
        do_op(2'b01, 8'h00);
        check("t4_pop_after", {24'd0, rsp_d}, 32'h0000_0017);
        check("t4_ovf_sticky", {31'd0, bus.stk_ovf}, 32'd1);
`else
        do_op(2'b00, 8'hEE);
        check("t4_wrap_wr", {31'd0, wr_seen}, 32'd1);
        check("t4_wrap_sp", {24'd0, bus.sp_out}, 32'h0000_00F6);
        check("t4_no_flag", {31'd0, bus.stk_ovf}, 32'd0);
`endif

        // 5: POP on an empty stack
        do_reset();
        do_op(2'b01, 8'h00);
`ifdef STACK_BOUNDS_CHECK_EN
        check("t5_unf_rsp", {22'd0, rsp_seen, rsp_r, rsp_e, rsp_d}, {22'd0, 3'b101, 8'h00});
        check("t5_unf_flag", {30'd0, bus.stk_ovf, bus.stk_unf}, 32'd1);
        check("t5_unf_sp", {24'd0, bus.sp_out}, 32'h0000_00FF);
        check("t5_unf_nord", {31'd0, rd_seen}, 32'd0);
`else
        check("t5_wrap_sp", {24'd0, bus.sp_out}, 32'h0000_0000);
        check("t5_wrap_rsp", {22'd0, rsp_seen, rsp_r, rsp_e, rsp_d}, {22'd0, 3'b100, 8'h07});
        check("t5_wrap_rd", {31'd0, rd_seen}, 32'd1);
`endif

        // 6: op_valid held high: three PUSHes over six cycles
        do_reset();
        @(negedge clk); #1;
        rn = 8'h77;
        bus.op_valid = 1'b1;
        bus.op_code  = 2'b00;
        wr_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (bus.mem_wr) wr_cnt++;
        end
        bus.op_valid = 1'b0;
        check("t6_wr_count", wr_cnt, 32'd3);
        check("t6_sp", {24'd0, bus.sp_out}, 32'h0000_00FC);
        check("t6_ready", {31'd0, bus.op_ready}, 32'd1);

        // Randomized traffic; the per-cycle compare does the checking.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk); #1;
            bus.op_valid = ($urandom_range(0, 3) != 0);
            bus.op_code  = 2'($urandom);
            rn  = 8'($urandom);
            npc = 8'($urandom);
        end
        @(negedge clk); #1;
        bus.op_valid = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
